lpc_record_packer: RTL

LPC_RECORD_PACKER -- requirements
Module: lpc_record_packer

---
 rtl/lpc_pkg.sv | 55 +++++
 rtl/lpc_fifo.sv | 55 +++++
 rtl/lpc_record_packer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC record packer: record layout,
// serializer FSM states and the byte-0 marker used by the host-side parser.
package lpc_pkg;

   localparam int CT_W      = 4;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 8;
   localparam int REC_W     = CT_W + ADDR_W + DATA_W + 1;
   localparam int NUM_BYTES = 6;

   localparam logic [2:0] LAST_IDX     = 3'(NUM_BYTES - 1);
   localparam logic [2:0] BYTE0_MARKER = 3'b101;

   // LPC 1.1 cycle type / direction field
   localparam logic [3:0] CT_IO_RD  = 4'h0;
   localparam logic [3:0] CT_IO_WR  = 4'h2;
   localparam logic [3:0] CT_MEM_RD = 4'h4;
   localparam logic [3:0] CT_MEM_WR = 4'h6;
   localparam logic [3:0] CT_DMA_RD = 4'h8;
   localparam logic [3:0] CT_DMA_WR = 4'hA;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   typedef struct packed {
      logic              ovf;
      logic [CT_W-1:0]   cyctype_dir;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } record_t;

   typedef struct packed {
      state_e     state;
      logic [2:0] idx;
   } dbg_t;

   // Wire format: marker/ovf/type byte, address MSB first, then data.
   function automatic logic [7:0] record_byte(input record_t rec, input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0:    b = {BYTE0_MARKER, rec.ovf, rec.cyctype_dir};
         3'd1:    b = rec.addr[31:24];
         3'd2:    b = rec.addr[23:16];
         3'd3:    b = rec.addr[15:8];
         3'd4:    b = rec.addr[7:0];
         3'd5:    b = rec.data;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lpc_fifo.sv
// Single-clock record FIFO; an extra pointer bit separates full from empty,
// and a push into a full FIFO is taken when a pop happens in the same cycle.
module lpc_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 45
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/lpc_record_packer.sv
// Captures decoded LPC cycles on the decoder strobe edge, queues them and
// serializes each as a 6-byte record over a valid/ready byte stream.
module lpc_record_packer
   import lpc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   lpc_clock,
   input  logic                   lpc_reset,
   input  logic                   in_strobe,
   input  logic [3:0]             in_cyctype_dir,
   input  logic [31:0]            in_addr,
   input  logic [7:0]             in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_byte,
   output logic [7:0]             drop_count,
   output logic [$clog2(DEPTH):0] fifo_level,
   output dbg_t                   dbg_state_o
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   // Output stream: out_byte is held while out_valid && !out_ready, and a
   // byte moves only on a cycle where out_valid && out_ready.
   state_e     state_q;
   logic [2:0] idx_q;
   logic       out_valid_q;

   logic       strobe_q, strobe_d;
   logic       ovf_q, ovf_d;
   logic [7:0] drop_q, drop_d;

   record_t    head, wr_rec;
   logic       fifo_full, fifo_empty;
   logic [LVL_W-1:0] level;

   logic strobe_edge, byte_acc, pop, push_ok, drop, more_after_pop;

   assign strobe_edge = in_strobe && !strobe_q;
   assign byte_acc    = out_valid_q && out_ready;
   assign pop         = byte_acc && (idx_q == LAST_IDX);
   assign push_ok     = strobe_edge && (!fifo_full || pop);
   assign drop        = strobe_edge && !push_ok;
   // Head is leaving this cycle; keep streaming if anything remains behind it.
   assign more_after_pop = (level > LVL_W'(1)) || push_ok;

   assign wr_rec = '{ovf: ovf_q, cyctype_dir: in_cyctype_dir, addr: in_addr, data: in_data};

   lpc_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk_i   (lpc_clock),
      .rst_ni  (lpc_reset),
      .push_i  (push_ok),
      .wdata_i (wr_rec),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   always_comb begin
      strobe_d = in_strobe;
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      if (push_ok) ovf_d = 1'b0;
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         strobe_q <= 1'b0;
         ovf_q    <= 1'b0;
         drop_q   <= 8'h00;
      end else begin
         strobe_q <= strobe_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty || push_ok) begin
                  state_q     <= SEND;
                  idx_q       <= 3'd0;
                  out_valid_q <= 1'b1;
               end
            end
            SEND: begin
               if (byte_acc) begin
                  if (idx_q == LAST_IDX) begin
                     idx_q <= 3'd0;
                     if (!more_after_pop) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                     end
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               idx_q       <= 3'd0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid   = out_valid_q;
   assign out_byte    = out_valid_q ? record_byte(head, idx_q) : 8'h00;
   assign drop_count  = drop_q;
   assign fifo_level  = level;
   assign dbg_state_o = '{state: state_q, idx: idx_q};

endmodule
